change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream stage of vending_machine. Consumes its change_o pulses and queues each refund.
//  Pays each refund out coin by coin through a req/ack handshake with the coin hopper.
//  Prefers dimes; falls back to nickles when the dime tube is empty.
//  Detects lost acks (timeout) and queue overflow.
// PARAMETERS
//  FIFO_DEPTH   4   refund queue entries (power of 2, >=2)
//  ACK_TIMEOUT  16  max cycles a req may stay high without ack before fault
//  AMT_W        3   refund amount width, units of 5 cents (matches vending_machine change_o)
// PORTS
//  clk_i          in   1      clock, all logic on rising edge
//  rst_ni         in   1      asynchronous active-low reset
//  change_i       in   AMT_W  refund amount in nickels; nonzero for one cycle = one refund event
//  dime_empty_i   in   1      hopper dime tube empty
//  nickle_empty_i in   1      hopper nickle tube empty
//  hopper_ack_i   in   1      hopper has ejected the requested coin (1-cycle pulse)
//  dime_req_o     out  1      request eject of one dime (10c)
//  nickle_req_o   out  1      request eject of one nickle (5c)
//  busy_o         out  1      refund queued or in progress
//  overflow_o     out  1      sticky: a refund was dropped because the queue was full
//  fault_o        out  1      sticky: ack timeout or required coin unavailable; halts dispensing
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, remaining=0, state IDLE. Reset mid-refund discards everything.
//  All outputs are registered. dime_req_o and nickle_req_o are never high together.
//  Push: edge samples change_i!=0 -> amount enqueued. change_i==0 is ignored.
//    Queue full at that edge and no pop at the same edge -> drop, overflow_o<=1.
//    Push and pop at the same edge on a full queue -> push accepted.
//  FSM: IDLE, SELECT, WAIT, FAULT.
//   IDLE: queue non-empty -> pop into remaining, go SELECT.
//   SELECT:
//    - remaining==0 -> IDLE.
//    - remaining>=2 and !dime_empty_i -> dime_req_o<=1, coin=2, go WAIT.
//    - else !nickle_empty_i -> nickle_req_o<=1, coin=1, go WAIT.
//    - else -> FAULT.
//   WAIT:
//    - req held high until hopper_ack_i sampled high.
//    - On ack: req<=0, remaining<=remaining-coin, go SELECT. Min 1 idle cycle between coins.
//    - Timeout counter clears on entry. If no ack for ACK_TIMEOUT consecutive cycles -> FAULT.
//      The req is high for exactly ACK_TIMEOUT cycles.
//    - hopper_ack_i is ignored outside WAIT.
//   FAULT: reqs 0, fault_o=1, queue pushes ignored (overflow_o not set). Exit only by reset.
//  Latency: push at edge E0 -> pop at E1 -> first req visible after E2.
//    Ack at edge Ea -> req low after Ea -> next req visible after Ea+1.
//  busy_o = (state!=IDLE) | queue non-empty, registered. Falls the cycle after returning to IDLE with the queue empty.
//  remaining never underflows: dime is chosen only when remaining>=2.
//  Queue pointers use wrap-around with an extra MSB to distinguish full from empty.
// CONFIGURATION
//  CHANGE_TOTAL_EN defined:
//    adds output coins_total_o [15:0] = total 5-cent units paid out.
//    Increments by coin on each accepted ack, saturates at 16'hFFFF, resets to 0.
//  CHANGE_TOTAL_EN undefined: port and counter absent, all other behaviour identical.
// TESTING
//  1. change_i=4 one cycle, tubes full, ack 1 cycle after each req
//     -> two dime handshakes, no nickle_req_o, busy_o low after last ack+2 cycles.
//  2. change_i=3, tubes full -> one dime then one nickle. coins_total_o=3 when CHANGE_TOTAL_EN is defined.
//  3. dime_empty_i=1, change_i=4 -> exactly four nickle_req_o handshakes, dime_req_o stays 0.
//  4. ack held low, change_i=1 on 6 consecutive cycles -> one in WAIT, 4 queued, 6th dropped, overflow_o=1.
//  5. change_i=1, ack never -> nickle_req_o high exactly 16 cycles, then fault_o=1, reqs 0.
//     Later pushes ignored.
//  6. change_i=5 with both tubes empty -> fault_o=1 after SELECT.
//     Separately: assert rst_ni=0 mid-WAIT -> all outputs 0 immediately, queue empty after release.

Source files
------------

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Downstream stage of vending_machine. Every nonzero change_i sample is one
// refund (in 5-cent units) that is queued and later paid out one coin at a
// time to the coin hopper. Dimes are preferred; nickles are used when the
// remaining amount is a single nickle or the dime tube is empty. A lost ack
// or a refund that no available coin can pay halts dispensing until reset.
//
// Optional feature (macro CHANGE_TOTAL_EN):
//   defined   -> adds coins_total_o, the saturating count of 5-cent units paid
//   undefined -> port and counter absent, behaviour otherwise identical
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   change_i        refund amount in nickles, nonzero for one cycle per refund
//   dime_empty_i    hopper dime tube empty
//   nickle_empty_i  hopper nickle tube empty
//   hopper_ack_i    hopper ejected the requested coin (1-cycle pulse)
//   dime_req_o      request eject of one dime
//   nickle_req_o    request eject of one nickle
//   busy_o          refund queued or in progress
//   overflow_o      sticky: refund dropped because the queue was full
//   fault_o         sticky: ack timeout or no usable coin; dispensing halted
//   coins_total_o   (CHANGE_TOTAL_EN only) total 5-cent units paid out
//
// Hopper handshake: a req output rises from SELECT and stays high until
// hopper_ack_i is sampled high at a rising edge; the req then drops at that
// same edge. At most one req is high at a time, and every coin is followed by
// at least one cycle with both reqs low. An ack seen while no req is pending
// is ignored.
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int AMT_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [AMT_W-1:0] change_i,
    input  logic             dime_empty_i,
    input  logic             nickle_empty_i,
    input  logic             hopper_ack_i,
    output logic             dime_req_o,
    output logic             nickle_req_o,
    output logic             busy_o,
    output logic             overflow_o,
`ifdef CHANGE_TOTAL_EN
    output logic [15:0]      coins_total_o,
`endif
    output logic             fault_o
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WAIT   = 2'd2,
        FAULT  = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Refund queue. Pointers carry one extra MSB so that equal low bits with
    // differing MSBs means full, fully equal pointers means empty.
    // ------------------------------------------------------------------------
    logic [AMT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             q_empty;
    logic             q_full;
    logic             push_req;
    logic             push;
    logic             pop;

    state_e           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic [1:0]       coin_q, coin_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             dime_req_q, dime_req_d;
    logic             nickle_req_q, nickle_req_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic             fault_q, fault_d;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

    // The FSM only pulls a refund while idle.
    assign pop = (state_q == IDLE) && !q_empty;

    // Refunds arriving after a fault are discarded silently.
    assign push_req = (change_i != '0) && (state_q != FAULT);
    // A full queue still accepts a refund when a slot frees at the same edge.
    assign push     = push_req && (!q_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= change_i;
        end
    end

    // ------------------------------------------------------------------------
    // Payout FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_d       = coin_q;
        tmo_d        = tmo_q;
        dime_req_d   = dime_req_q;
        nickle_req_d = nickle_req_q;
        fault_d      = fault_q;

        unique case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    remaining_d = mem_q[rd_ptr_q[PTR_W-2:0]];
                    state_d     = SELECT;
                end
            end

            SELECT: begin
                if (remaining_q == '0) begin
                    state_d = IDLE;
                end else if ((remaining_q >= AMT_W'(2)) && !dime_empty_i) begin
                    // Dime only when at least two nickles are owed, so the
                    // subtraction in WAIT can never wrap.
                    dime_req_d = 1'b1;
                    coin_d     = 2'd2;
                    tmo_d      = '0;
                    state_d    = WAIT;
                end else if (!nickle_empty_i) begin
                    nickle_req_d = 1'b1;
                    coin_d       = 2'd1;
                    tmo_d        = '0;
                    state_d      = WAIT;
                end else begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end
            end

            WAIT: begin
                if (hopper_ack_i) begin
                    dime_req_d   = 1'b0;
                    nickle_req_d = 1'b0;
                    remaining_d  = remaining_q - AMT_W'(coin_q);
                    state_d      = SELECT;
                end else if (tmo_q == TMO_LAST) begin
                    // This edge ends the ACK_TIMEOUT-th cycle of req high.
                    dime_req_d   = 1'b0;
                    nickle_req_d = 1'b0;
                    fault_d      = 1'b1;
                    state_d      = FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            FAULT: begin
                dime_req_d   = 1'b0;
                nickle_req_d = 1'b0;
                fault_d      = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_q != IDLE) || !q_empty;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_q       <= '0;
            tmo_q        <= '0;
            dime_req_q   <= 1'b0;
            nickle_req_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_q       <= coin_d;
            tmo_q        <= tmo_d;
            dime_req_q   <= dime_req_d;
            nickle_req_q <= nickle_req_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            fault_q      <= fault_d;
        end
    end

`ifdef CHANGE_TOTAL_EN
    logic [15:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if ((state_q == WAIT) && hopper_ack_i) begin
            if (total_q > (16'hFFFF - {14'd0, coin_q})) begin
                total_d = 16'hFFFF;
            end else begin
                total_d = total_q + {14'd0, coin_q};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign coins_total_o = total_q;
`endif

    assign dime_req_o   = dime_req_q;
    assign nickle_req_o = nickle_req_q;
    assign busy_o       = busy_q;
    assign overflow_o   = overflow_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Bench for change_dispenser. The bench plays the coin hopper. Inputs are
// driven and outputs sampled on the falling clock edge. The expected coin
// sequence for each refund comes from the greedy payout rule (dimes while at
// least two nickles are owed and dimes are available, otherwise nickles).
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int AMT_W = 3;

    logic             clk;
    logic             rst_n;
    logic [AMT_W-1:0] change;
    logic             dime_empty;
    logic             nickle_empty;
    logic             hopper_ack;
    logic             dime_req;
    logic             nickle_req;
    logic             busy;
    logic             overflow;
    logic             fault;
`ifdef CHANGE_TOTAL_EN
    logic [15:0]      coins_total;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: expected coin values (1 = nickle, 2 = dime) in payout order
    logic [1:0] exp_q[$];
    int         total_model = 0;

    change_dispenser #(
        .FIFO_DEPTH (4),
        .ACK_TIMEOUT(16),
        .AMT_W      (AMT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .change_i      (change),
        .dime_empty_i  (dime_empty),
        .nickle_empty_i(nickle_empty),
        .hopper_ack_i  (hopper_ack),
        .dime_req_o    (dime_req),
        .nickle_req_o  (nickle_req),
        .busy_o        (busy),
        .overflow_o    (overflow),
`ifdef CHANGE_TOTAL_EN
        .coins_total_o (coins_total),
`endif
        .fault_o       (fault)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n        = 1'b0;
        change       = '0;
        hopper_ack   = 1'b0;
        dime_empty   = 1'b0;
        nickle_empty = 1'b0;
        exp_q.delete();
        total_model = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Greedy payout rule applied to one refund amount.
    task automatic model_refund(input int amt, input bit dimes_out);
        int r;
        r = amt;
        while (r > 0) begin
            if (r >= 2 && !dimes_out) begin
                exp_q.push_back(2'd2);
                r -= 2;
            end else begin
                exp_q.push_back(2'd1);
                r -= 1;
            end
        end
        total_model += amt;
    endtask

    // Drive one refund for one cycle; returns on the falling edge after it
    // was sampled.
    task automatic push_amt(input int amt);
        change = AMT_W'(amt);
        @(negedge clk);
        change = '0;
        model_refund(amt, dime_empty);
    endtask

    // Act as the hopper until every expected coin has been paid, then check
    // busy drops exactly two cycles after the final ack.
    task automatic serve_all(input int max_delay);
        int   waited;
        int   d;
        logic [1:0] coin;
        logic [1:0] exp_coin;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (!(dime_req || nickle_req) && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (!(dime_req || nickle_req)) begin
                chk("req_wait_expired", 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
            chk("req_exclusive", {31'd0, dime_req & nickle_req}, 32'd0);
            coin     = dime_req ? 2'd2 : 2'd1;
            exp_coin = exp_q.pop_front();
            chk("coin_kind", {30'd0, coin}, {30'd0, exp_coin});
            d = $urandom_range(0, max_delay);
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                chk("req_hold", {30'd0, dime_req, nickle_req},
                    (exp_coin == 2'd2) ? 32'd2 : 32'd1);
            end
            hopper_ack = 1'b1;
            @(negedge clk);
            hopper_ack = 1'b0;
            chk("req_drop_after_ack", {30'd0, dime_req, nickle_req}, 32'd0);
        end
        @(negedge clk);
        chk("busy_ack_plus1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_ack_plus2", {31'd0, busy}, 32'd0);
`ifdef CHANGE_TOTAL_EN
        chk("coins_total", {16'd0, coins_total}, total_model);
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cnt;
        int nb;

        // reset state
        do_reset();
        chk("reset_dime_req", {31'd0, dime_req}, 32'd0);
        chk("reset_nickle_req", {31'd0, nickle_req}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_fault", {31'd0, fault}, 32'd0);
`ifdef CHANGE_TOTAL_EN
        chk("reset_total", {16'd0, coins_total}, 32'd0);
`endif

        // ack outside WAIT must be ignored
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored", {29'd0, dime_req, nickle_req, busy}, 32'd0);

        // 1: four nickles owed, tubes full -> two dimes, exact first-req latency
        push_amt(4);
        chk("lat_busy_e1", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("lat_busy_e2", {31'd0, busy}, 32'd1);
        chk("lat_no_req_e1", {30'd0, dime_req, nickle_req}, 32'd0);
        @(negedge clk);
        chk("lat_dime_req_e2", {30'd0, dime_req, nickle_req}, 32'd2);
        serve_all(0);

        // 2: three owed -> dime then nickle
        push_amt(3);
        serve_all(1);

        // 3: dime tube empty -> four nickles
        dime_empty = 1'b1;
        push_amt(4);
        serve_all(2);
        dime_empty = 1'b0;

        // random refunds, possibly several queued back to back
        for (int it = 0; it < 10; it++) begin
            dime_empty = ($urandom_range(0, 3) == 0);
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                push_amt($urandom_range(1, 7));
            end
            serve_all(3);
        end
        dime_empty = 1'b0;
        chk("random_no_overflow", {31'd0, overflow}, 32'd0);
        chk("random_no_fault", {31'd0, fault}, 32'd0);

        // 4: ack held low, six back-to-back refunds -> sixth dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            change = AMT_W'(1);
            if (i == 5) chk("overflow_before_6th", {31'd0, overflow}, 32'd0);
            @(negedge clk);
        end
        change = '0;
        chk("overflow_after_6th", {31'd0, overflow}, 32'd1);
        chk("overflow_nickle_waiting", {30'd0, dime_req, nickle_req}, 32'd1);

        // 5: ack never arrives -> req high exactly ACK_TIMEOUT cycles
        do_reset();
        push_amt(1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nickle_req) cnt++;
            chk("timeout_no_dime", {31'd0, dime_req}, 32'd0);
        end
        chk("timeout_req_cycles", cnt, 32'd16);
        chk("timeout_fault", {31'd0, fault}, 32'd1);
        chk("timeout_reqs_low", {30'd0, dime_req, nickle_req}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            change = AMT_W'($urandom_range(1, 7));
            @(negedge clk);
        end
        change = '0;
        repeat (4) @(negedge clk);
        chk("fault_push_no_overflow", {31'd0, overflow}, 32'd0);
        chk("fault_push_no_req", {30'd0, dime_req, nickle_req}, 32'd0);
        chk("fault_sticky", {31'd0, fault}, 32'd1);

        // 6a: both tubes empty -> fault right after SELECT
        do_reset();
        dime_empty   = 1'b1;
        nickle_empty = 1'b1;
        push_amt(5);
        chk("empty_fault_e0", {31'd0, fault}, 32'd0);
        @(negedge clk);
        chk("empty_fault_e1", {31'd0, fault}, 32'd0);
        @(negedge clk);
        chk("empty_fault_e2", {31'd0, fault}, 32'd1);
        chk("empty_no_req", {30'd0, dime_req, nickle_req}, 32'd0);

        // 6b: reset asserted mid-WAIT clears outputs immediately
        do_reset();
        push_amt(4);
        push_amt(2);
        cnt = 0;
        while (!dime_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("midwait_req_seen", {31'd0, dime_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {27'd0, dime_req, nickle_req, busy, overflow, fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("post_reset_queue_empty", {29'd0, busy, dime_req, nickle_req}, 32'd0);
`ifdef CHANGE_TOTAL_EN
        chk("post_reset_total", {16'd0, coins_total}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
